// File: rtl/nn_pkg.sv
// Shared definitions for the output-neuron datapath: format defaults,
// accumulator sizing and the controller state encoding.
package nn_pkg;

  localparam int HIDDEN_W_DEF = 10;
  localparam int WEIGHT_W_DEF = 8;
  localparam int FRAC_BITS    = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Product width plus growth for NUM_HIDDEN products and one bias term.
  function automatic int acc_width(input int hidden_w, input int weight_w, input int num_hidden);
    return hidden_w + weight_w + 1 + $clog2(num_hidden + 1);
  endfunction

endpackage

// File: rtl/output_neuron_mac_if.sv
// Weight-load, hidden-value stream and result handshake of the output neuron.
interface output_neuron_mac_if import nn_pkg::*; #(
  parameter int NUM_HIDDEN = 4,
  parameter int HIDDEN_W   = HIDDEN_W_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF
) ();

  localparam int ADDR_W = $clog2(NUM_HIDDEN + 1);

  logic                       w_we_i;
  logic [ADDR_W-1:0]          w_addr_i;
  logic signed [WEIGHT_W-1:0] w_data_i;
  logic                       start_i;
  logic                       h_valid_i;
  logic [HIDDEN_W-1:0]        h_data_i;
  logic                       h_ready_o;
  logic                       y_valid_o;
  logic                       y_ready_i;
  logic [HIDDEN_W-1:0]        y_o;
  logic                       busy_o;

  modport slave (
    input  w_we_i, w_addr_i, w_data_i, start_i, h_valid_i, h_data_i, y_ready_i,
    output h_ready_o, y_valid_o, y_o, busy_o
  );

  modport master (
    output w_we_i, w_addr_i, w_data_i, start_i, h_valid_i, h_data_i, y_ready_i,
    input  h_ready_o, y_valid_o, y_o, busy_o
  );

endinterface

// File: rtl/fx_mac.sv
// Signed multiply-accumulate: unsigned sample times signed coefficient,
// with synchronous clear, load of an initial value, and accumulate enable.
module fx_mac import nn_pkg::*; #(
  parameter int A_W   = HIDDEN_W_DEF,
  parameter int B_W   = WEIGHT_W_DEF,
  parameter int ACC_W = acc_width(HIDDEN_W_DEF, WEIGHT_W_DEF, 4)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic                    en,
  input  logic [A_W-1:0]          a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W + 1;

  logic signed [P_W-1:0] a_x;
  logic signed [P_W-1:0] b_x;
  logic signed [P_W-1:0] prod;

  // Zero-extend the sample so it is never read as negative.
  assign a_x  = signed'({{(P_W-A_W){1'b0}}, a});
  assign b_x  = {{(P_W-B_W){b[B_W-1]}}, b};
  assign prod = a_x * b_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/output_neuron_mac.sv
// Output neuron: weighted sum of NUM_HIDDEN hidden values, ReLU and saturation.
// Define OUTPUT_NEURON_BIAS_EN to add a bias register at weight index NUM_HIDDEN.
module output_neuron_mac import nn_pkg::*; #(
  parameter int NUM_HIDDEN = 4,
  parameter int HIDDEN_W   = HIDDEN_W_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output_neuron_mac_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_HIDDEN + 1);
  localparam int ACC_W  = acc_width(HIDDEN_W, WEIGHT_W, NUM_HIDDEN);
  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(NUM_HIDDEN - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'((1 << HIDDEN_W) - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic [ADDR_W-1:0]          count;
  logic signed [WEIGHT_W-1:0] weight [NUM_HIDDEN];
  logic signed [WEIGHT_W-1:0] w_sel;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_init;
  logic                       start_acc;
  logic                       mac_en;
  logic                       mac_clr;
  logic                       mac_load;
  logic                       w_ok;

  function automatic logic [HIDDEN_W-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] q;
    q = a >>> FRAC_BITS;
    if (q[ACC_W-1]) return '0;
    if (q > Y_MAX)  return '1;
    return q[HIDDEN_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.h_ready_o = 1'b0;
    bus.y_valid_o = 1'b0;
    bus.busy_o    = 1'b1;
    start_acc     = 1'b0;
    mac_en        = 1'b0;
    case (state)
      IDLE: begin
        bus.busy_o = 1'b0;
        if (bus.start_i) begin
          state_nxt = ACCUM;
          start_acc = 1'b1;
        end
      end
      ACCUM: begin
        bus.h_ready_o = 1'b1;
        if (bus.h_valid_i) begin
          mac_en = 1'b1;
          if (count == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE: begin
        bus.y_valid_o = 1'b1;
        if (bus.y_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)         count <= '0;
    else if (start_acc) count <= '0;
    else if (mac_en)    count <= count + ADDR_W'(1);
  end

  // A start in the same cycle wins over a weight write.
  assign w_ok = bus.w_we_i && (state == IDLE) && !bus.start_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_HIDDEN; i++) weight[i] <= '0;
    end else if (w_ok) begin
      for (int i = 0; i < NUM_HIDDEN; i++) begin
        if (bus.w_addr_i == ADDR_W'(i)) weight[i] <= bus.w_data_i;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_HIDDEN; i++) begin
      if (count == ADDR_W'(i)) w_sel = weight[i];
    end
  end

`ifdef OUTPUT_NEURON_BIAS_EN
  localparam logic [ADDR_W-1:0] BIAS_IDX = ADDR_W'(NUM_HIDDEN);

  logic signed [WEIGHT_W-1:0] bias;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                 bias <= '0;
    else if (w_ok && bus.w_addr_i == BIAS_IDX)  bias <= bus.w_data_i;
  end

  // Bias is 1.7 like the weights; align it to the 3.7 x 1.7 product scale.
  assign acc_init = {{(ACC_W-WEIGHT_W){bias[WEIGHT_W-1]}}, bias} <<< FRAC_BITS;
  assign mac_clr  = 1'b0;
  assign mac_load = start_acc;
`else
  assign acc_init = '0;
  assign mac_clr  = start_acc;
  assign mac_load = 1'b0;
`endif

  fx_mac #(
    .A_W   (HIDDEN_W),
    .B_W   (WEIGHT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .clr      (mac_clr),
    .load     (mac_load),
    .load_val (acc_init),
    .en       (mac_en),
    .a        (bus.h_data_i),
    .b        (w_sel),
    .acc      (acc)
  );

  // Accumulator is frozen in DONE, so the result holds through a stall.
  assign bus.y_o = (state == DONE) ? relu_sat(acc) : '0;

endmodule

// File: tb/tb_output_neuron_mac.sv
// Self-checking bench for output_neuron_mac: vector table, corner sequences,
// and randomized inferences against an arithmetic reference model.
module tb_output_neuron_mac;

  localparam int NH = 4;
  localparam int HW = 10;
  localparam int WW = 8;
  localparam int AW = $clog2(NH + 1);
`ifdef OUTPUT_NEURON_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic signed [WW-1:0] mw [NH];
  logic signed [WW-1:0] mb;

  typedef struct {
    logic [NH*WW-1:0] w;
    logic [NH*HW-1:0] h;
    logic [HW-1:0]    exp;
  } vec_t;

  vec_t vecs [6];

  output_neuron_mac_if #(.NUM_HIDDEN(NH), .HIDDEN_W(HW), .WEIGHT_W(WW)) bus ();

  output_neuron_mac #(.NUM_HIDDEN(NH), .HIDDEN_W(HW), .WEIGHT_W(WW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic int model_y(input logic [NH*HW-1:0] hv);
    longint acc;
    acc = BIAS_EN ? longint'(mb) * 128 : 0;
    for (int i = 0; i < NH; i++) acc += longint'(hv[i*HW +: HW]) * longint'(mw[i]);
    acc = acc >>> 7;
    if (acc < 0) return 0;
    if (acc > 1023) return 1023;
    return int'(acc);
  endfunction

  task automatic write_w(input int addr, input logic [WW-1:0] data);
    bus.w_we_i   = 1'b1;
    bus.w_addr_i = AW'(addr);
    bus.w_data_i = data;
    tick();
    bus.w_we_i   = 1'b0;
    if (addr < NH) mw[addr] = data;
    else if (addr == NH) mb = data;
  endtask

  task automatic do_inf(input logic [NH*HW-1:0] hv, input bit gaps, input int stall,
                        input bit noise, input bit wr_with_start, output logic [HW-1:0] y);
    logic [HW-1:0] y0;
    bus.start_i = 1'b1;
    if (wr_with_start) begin
      bus.w_we_i   = 1'b1;
      bus.w_addr_i = '0;
      bus.w_data_i = 8'h80;
    end
    tick();
    bus.start_i = 1'b0;
    bus.w_we_i  = 1'b0;
    check("busy_after_start", bus.busy_o, 1);
    for (int i = 0; i < NH; i++) begin
      if (gaps) begin
        bus.h_valid_i = 1'b0;
        bus.h_data_i  = HW'($urandom);
        if (noise) begin
          bus.w_we_i   = 1'b1;
          bus.w_addr_i = AW'(i);
          bus.w_data_i = WW'($urandom);
          bus.start_i  = 1'b1;
        end
        tick();
        bus.w_we_i  = 1'b0;
        bus.start_i = 1'b0;
      end
      bus.h_valid_i = 1'b1;
      bus.h_data_i  = hv[i*HW +: HW];
      check("h_ready_accum", bus.h_ready_o, 1);
      tick();
    end
    bus.h_valid_i = 1'b0;
    check("y_valid_after_last_beat", bus.y_valid_o, 1);
    y0 = bus.y_o;
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        bus.w_we_i   = 1'b1;
        bus.w_addr_i = AW'(s % NH);
        bus.w_data_i = WW'($urandom);
        bus.start_i  = 1'b1;
      end
      tick();
      bus.w_we_i  = 1'b0;
      bus.start_i = 1'b0;
      check("y_valid_stall", bus.y_valid_o, 1);
      check("y_stable_stall", bus.y_o, y0);
    end
    bus.y_ready_i = 1'b1;
    y = bus.y_o;
    tick();
    bus.y_ready_i = 1'b0;
    check("y_valid_drop", bus.y_valid_o, 0);
    check("busy_drop", bus.busy_o, 0);
  endtask

  initial begin
    logic [HW-1:0]    y;
    logic [NH*HW-1:0] hv;
    int               exp;

    bus.w_we_i = 1'b0;  bus.w_addr_i = '0; bus.w_data_i = '0;
    bus.start_i = 1'b0; bus.h_valid_i = 1'b0; bus.h_data_i = '0;
    bus.y_ready_i = 1'b0;
    for (int i = 0; i < NH; i++) mw[i] = '0;
    mb = '0;

    vecs[0] = '{32'h40404040, {4{10'h080}}, 10'h100};
    vecs[1] = '{32'h80808080, {4{10'h080}}, 10'h000};
    vecs[2] = '{32'h7F7F7F7F, {4{10'h3FF}}, 10'h3FF};
    vecs[3] = '{32'h00208040, {10'h3FF, 10'h200, 10'h080, 10'h100}, 10'h080};
    vecs[4] = '{32'h00000003, {10'h000, 10'h000, 10'h000, 10'h02B}, 10'h001};
    vecs[5] = '{32'h01010101, {4{10'h3FF}}, 10'h01F};

    #2;
    check("reset_y_valid", bus.y_valid_o, 0);
    check("reset_h_ready", bus.h_ready_o, 0);
    check("reset_busy", bus.busy_o, 0);
    check("reset_y", bus.y_o, 0);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NH; i++) write_w(i, vecs[v].w[i*WW +: WW]);
      do_inf(vecs[v].h, 1'b0, 0, 1'b0, 1'b0, y);
      check($sformatf("vec%0d_y", v), y, vecs[v].exp);
    end

    // Gaps, 5-cycle result stall, writes and starts while busy.
    for (int i = 0; i < NH; i++) write_w(i, 8'h40);
    do_inf({4{10'h080}}, 1'b1, 5, 1'b1, 1'b0, y);
    check("stall_noise_y", y, 10'h100);
    do_inf({4{10'h080}}, 1'b0, 0, 1'b0, 1'b0, y);
    check("busy_write_dropped_y", y, 10'h100);

    // Write colliding with start is dropped; inference uses old weights.
    do_inf({4{10'h080}}, 1'b0, 0, 1'b0, 1'b1, y);
    check("start_write_same_cycle_y", y, 10'h100);
    do_inf({4{10'h080}}, 1'b0, 0, 1'b0, 1'b0, y);
    check("start_write_not_landed_y", y, 10'h100);

    // Hidden values offered while idle are ignored.
    bus.h_valid_i = 1'b1;
    bus.h_data_i  = 10'h3FF;
    tick();
    check("idle_h_ready", bus.h_ready_o, 0);
    tick();
    bus.h_valid_i = 1'b0;
    do_inf({4{10'h080}}, 1'b0, 0, 1'b0, 1'b0, y);
    check("idle_h_ignored_y", y, 10'h100);

    // Bias slot and out-of-range addresses.
    for (int i = 0; i < NH; i++) write_w(i, 8'h00);
    write_w(NH, 8'h40);
    for (int a = NH + 1; a < (1 << AW); a++) write_w(a, 8'h7F);
    do_inf({10'h123, 10'h3FF, 10'h001, 10'h2AA}, 1'b0, 0, 1'b0, 1'b0, y);
    check("bias_y", y, BIAS_EN ? 10'h040 : 10'h000);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NH; i++) write_w(i, WW'($urandom));
      if ($urandom_range(0, 1) == 1) write_w(NH, WW'($urandom));
      for (int i = 0; i < NH; i++) hv[i*HW +: HW] = HW'($urandom);
      exp = model_y(hv);
      do_inf(hv, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, y);
      check($sformatf("rand%0d_y", r), y, exp);
    end

    // Reset in the middle of an inference.
    for (int i = 0; i < NH; i++) write_w(i, 8'h40);
    bus.start_i = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    bus.h_valid_i = 1'b1;
    bus.h_data_i  = 10'h080;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    check("midreset_y_valid", bus.y_valid_o, 0);
    check("midreset_busy", bus.busy_o, 0);
    check("midreset_h_ready", bus.h_ready_o, 0);
    for (int i = 0; i < NH; i++) mw[i] = '0;
    mb = '0;
    tick(); tick();
    rst_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_reset_no_y_valid", bus.y_valid_o, 0);
    end
    bus.h_valid_i = 1'b0;
    hv = {4{10'h080}};
    exp = model_y(hv);
    do_inf(hv, 1'b0, 0, 1'b0, 1'b0, y);
    check("post_reset_cleared_model_y", y, exp);
    check("post_reset_cleared_y", y, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
